imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words held (power of two, 2..1024).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response (1..15).
REQ-003 Parameter NOP_WORD, default 32'h0000_0000, word returned on a faulted fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pc  input  32  byte address of the requested instruction, sampled on acceptance.
REQ-007 fetch_req  input  1  fetch request; accepted on a rising edge when ready=1.
REQ-008 ready  output  1  high when a new fetch_req will be accepted this cycle.
REQ-009 inst  output  32  fetched instruction word; holds its last value between responses.
REQ-010 inst_valid  output  1  one-cycle pulse marking inst/fault as the response.
REQ-011 fault  output  1  qualified by inst_valid: request was misaligned or out of range.
REQ-012 ld_en  input  1  program-load write strobe.
REQ-013 ld_addr  input  $clog2(DEPTH)  word index for the program-load write.
REQ-014 ld_data  input  32  program-load write data.

Function
REQ-015 FSM states IDLE, WAIT, RESP; ready=1 in IDLE and RESP, 0 in WAIT.
REQ-016 IDLE: fetch_req=1 -> capture pc into pc_q, load cnt=LATENCY-1, go WAIT; else stay.
REQ-017 WAIT: cnt!=0 -> cnt decrements; cnt==0 -> register response into inst/fault, go RESP.
REQ-018 RESP: inst_valid=1 for exactly this cycle; fetch_req=1 -> accept as in IDLE (go WAIT), else go IDLE.
REQ-019 Latency: request accepted at edge N -> inst_valid high in the cycle after edge N+LATENCY.
REQ-020 Throughput: back-to-back requests return one response every LATENCY+1 cycles.
REQ-021 fetch_req in WAIT is ignored (not queued); the requester re-presents it once ready=1.
REQ-022 fault=1 when pc_q[1:0]!=0 or pc_q[31:2]>=DEPTH; the response is then inst=NOP_WORD.
REQ-023 Non-fault response: inst=mem[pc_q[$clog2(DEPTH)+1:2]].
REQ-024 ld_en=1 writes ld_data to mem[ld_addr] on the edge; accepted in any state.
REQ-025 Load and response-capture edge to the same word: the response carries ld_data (write-first bypass).
REQ-026 A load to the same word earlier in WAIT is visible in the response; a load after the capture edge is not.
REQ-027 pc changing after acceptance has no effect on the pending response.
REQ-028 Memory contents are not cleared by reset; unloaded words read as X in simulation.

Reset
REQ-029 reset=1 asynchronously forces state=IDLE, cnt=0, pc_q=0, inst=0, inst_valid=0, fault=0.
REQ-030 A fetch in flight at reset is discarded; no inst_valid pulse follows reset release.
REQ-031 ld_en is ignored while reset=1.
REQ-032 ready=1 in the first cycle after reset deasserts.

Verification
REQ-033 Load word0=32'h00421006 and word1=32'h2042000A; fetch pc=0, then pc=4 -> inst_valid 2 cycles after each acceptance, inst=00421006 then 2042000A, fault=0, 3-cycle spacing.
REQ-034 Fetch pc=32'h2 -> inst_valid with fault=1 and inst=0; fetch pc=32'h100 (word 64, DEPTH=64) -> fault=1, inst=0.
REQ-035 Hold fetch_req=1 for 10 cycles with pc=0 -> ready low during WAIT only, exactly 3 inst_valid pulses, none lost or duplicated.
REQ-036 Fetch pc=8 with word2=32'hAAAA_AAAA; on the capture edge write ld_addr=2, ld_data=32'h5555_5555 -> response inst=5555_5555. Repeat with the write one edge after capture -> inst=AAAA_AAAA.
REQ-037 Assert reset mid-WAIT -> outputs zero immediately, no later inst_valid, ready=1 after release, memory contents intact on the next fetch.
REQ-038 LATENCY=1 build: accept at edge N -> inst_valid after edge N+1; back-to-back responses every 2 cycles.

Source files
------------

// File: rtl/imem_resp_if.sv
// Fetch and program-load bus for the instruction memory responder.
// The requester (core/loader) is the master; the memory is the slave.
interface imem_resp_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc;
    logic          fetch_req;
    logic          ready;
    logic [31:0]   inst;
    logic          inst_valid;
    logic          fault;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    modport master (
        output pc, fetch_req, ld_en, ld_addr, ld_data,
        input  ready, inst, inst_valid, fault
    );

    modport slave (
        input  pc, fetch_req, ld_en, ld_addr, ld_data,
        output ready, inst, inst_valid, fault
    );
endinterface

// File: rtl/imem_resp.sv
// Fixed-latency instruction fetch responder with a program-load write port.
// One fetch in flight at a time; misaligned or out-of-range fetches return NOP_WORD with fault.
module imem_resp #(
    parameter int          DEPTH    = 64,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    imem_resp_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [31:0]   pc_q_reg, pc_q_next;
    logic [31:0]   inst_reg, inst_next;
    logic          fault_reg, fault_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic          rd_fault;
    logic [31:0]   rd_word;
    logic          load_we;

    // Loads are blocked while reset is held; memory itself is never cleared.
    assign load_we = bus.ld_en && !reset;

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign rd_idx   = pc_q_reg[AW+1:2];
    assign rd_fault = (pc_q_reg[1:0] != 2'b00) || (pc_q_reg[31:2] >= 30'(DEPTH));
    // A load landing on the capture edge wins over the stored word.
    assign rd_word  = (bus.ld_en && (bus.ld_addr == rd_idx)) ? bus.ld_data : mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            pc_q_reg  <= 32'd0;
            inst_reg  <= 32'd0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pc_q_reg  <= pc_q_next;
            inst_reg  <= inst_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_q_next  = pc_q_reg;
        inst_next  = inst_reg;
        fault_next = fault_reg;

        case (state_reg)
            IDLE, RESP: begin
                if (bus.fetch_req) begin
                    pc_q_next  = bus.pc;
                    cnt_next   = CNT_INIT;
                    state_next = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                // Requests arriving here are dropped; ready is low so the requester retries.
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    inst_next  = rd_fault ? NOP_WORD : rd_word;
                    fault_next = rd_fault;
                    state_next = RESP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready      = (state_reg != WAIT);
    assign bus.inst_valid = (state_reg == RESP);
    assign bus.inst       = inst_reg;
    assign bus.fault      = fault_reg;
endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: a LATENCY=2 instance for the main scenarios and a LATENCY=1 instance for timing.
module tb_imem_resp;
    localparam int DEPTH = 64;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_resp_if #(.DEPTH(DEPTH)) f0 ();
    imem_resp_if #(.DEPTH(DEPTH)) f1 ();

    imem_resp #(.DEPTH(DEPTH), .LATENCY(LAT0), .NOP_WORD(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .bus(f0)
    );
    imem_resp #(.DEPTH(DEPTH), .LATENCY(LAT1), .NOP_WORD(32'h0000_0000)) dut1 (
        .clk(clk), .reset(reset), .bus(f1)
    );

    typedef struct {
        logic [31:0] inst;
        logic        fault;
        int          acc;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        e0, e1;
    logic [31:0] model_mem [DEPTH];
    int n_tests = 0, n_fail = 0;
    int pulses0 = 0, pulses1 = 0;

    function automatic exp_t model_exp(input logic [31:0] a, input int acc);
        exp_t e;
        e.fault = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        e.inst  = e.fault ? 32'h0000_0000 : model_mem[a[7:2]];
        e.acc   = acc;
        return e;
    endfunction

    // Response scoreboards: every inst_valid pulse must match the oldest accepted fetch.
    always @(negedge clk) begin
        if (f0.inst_valid === 1'b1) begin
            pulses0++;
            n_tests++;
            if (sb0.size() == 0) begin
                n_fail++;
                $display("FAIL resp0_unexpected: inst_valid at cycle %0d, inst=%h, no fetch pending", cyc, f0.inst);
            end else begin
                e0 = sb0.pop_front();
                if (f0.inst !== e0.inst || f0.fault !== e0.fault || (cyc - e0.acc) != LAT0) begin
                    n_fail++;
                    $display("FAIL resp0: got inst=%h fault=%b latency=%0d, want inst=%h fault=%b latency=%0d",
                             f0.inst, f0.fault, cyc - e0.acc, e0.inst, e0.fault, LAT0);
                end else begin
                    $display("[TB] dut0 resp cycle=%0d inst=%h fault=%b", cyc, f0.inst, f0.fault);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (f1.inst_valid === 1'b1) begin
            pulses1++;
            n_tests++;
            if (sb1.size() == 0) begin
                n_fail++;
                $display("FAIL resp1_unexpected: inst_valid at cycle %0d, inst=%h, no fetch pending", cyc, f1.inst);
            end else begin
                e1 = sb1.pop_front();
                if (f1.inst !== e1.inst || f1.fault !== e1.fault || (cyc - e1.acc) != LAT1) begin
                    n_fail++;
                    $display("FAIL resp1: got inst=%h fault=%b latency=%0d, want inst=%h fault=%b latency=%0d",
                             f1.inst, f1.fault, cyc - e1.acc, e1.inst, e1.fault, LAT1);
                end else begin
                    $display("[TB] dut1 resp cycle=%0d inst=%h fault=%b", cyc, f1.inst, f1.fault);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic [31:0] a);
        f0.fetch_req = req;
        f0.pc        = a;
        if (req && f0.ready === 1'b1) sb0.push_back(model_exp(a, cyc + 1));
        tick();
    endtask

    task automatic drive1(input logic req, input logic [31:0] a);
        f1.fetch_req = req;
        f1.pc        = a;
        if (req && f1.ready === 1'b1) sb1.push_back(model_exp(a, cyc + 1));
        tick();
    endtask

    task automatic issue0(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            ok = (f0.ready === 1'b1);
            drive0(1'b1, a);
        end
        f0.fetch_req = 1'b0;
    endtask

    task automatic drain0(output bit ok);
        for (int i = 0; i < 20 && sb0.size() != 0; i++) drive0(1'b0, 32'd0);
        ok = (sb0.size() == 0);
    endtask

    task automatic drain1(output bit ok);
        for (int i = 0; i < 20 && sb1.size() != 0; i++) drive1(1'b0, 32'd0);
        ok = (sb1.size() == 0);
    endtask

    task automatic do_load(input logic [5:0] addr, input logic [31:0] data);
        f0.ld_en = 1'b1; f0.ld_addr = addr; f0.ld_data = data;
        f1.ld_en = 1'b1; f1.ld_addr = addr; f1.ld_data = data;
        tick();
        f0.ld_en = 1'b0;
        f1.ld_en = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic test_reset();
        f0.fetch_req = 0; f0.pc = 0; f0.ld_en = 0; f0.ld_addr = 0; f0.ld_data = 0;
        f1.fetch_req = 0; f1.pc = 0; f1.ld_en = 0; f1.ld_addr = 0; f1.ld_data = 0;
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (f0.inst !== 32'd0 || f0.fault !== 1'b0 || f0.inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got inst=%h fault=%b valid=%b, want 0/0/0", f0.inst, f0.fault, f0.inst_valid);
        end
        n_tests++;
        if (f0.ready !== 1'b1 || f1.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got ready0=%b ready1=%b, want 1/1", f0.ready, f1.ready);
        end
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if (f0.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, want 1", f0.ready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base, t0, npc;
        do_load(6'd0, 32'h0042_1006);
        do_load(6'd1, 32'h2042_000A);
        do_load(6'd2, 32'hAAAA_AAAA);
        do_load(6'd63, 32'hDEAD_BEEF);
        base = pulses0;
        t0   = 0;
        npc  = 0;
        for (int i = 0; i < 20 && pulses0 - base < 2; i++) begin
            if (npc < 2 && f0.ready === 1'b1) begin
                drive0(1'b1, 32'(npc * 4));
                npc++;
            end else begin
                drive0(1'b0, 32'd0);
            end
            if (pulses0 - base == 1 && t0 == 0) t0 = cyc;
        end
        n_tests++;
        if (pulses0 - base != 2 || cyc - t0 != LAT0 + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d pulses spaced %0d, want 2 spaced %0d", pulses0 - base, cyc - t0, LAT0 + 1);
        end
        drain0(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, want 0", sb0.size());
        end
    endtask

    task automatic test_fault();
        bit ok;
        logic [31:0] pcs [4];
        pcs[0] = 32'h0000_0002; pcs[1] = 32'h0000_0100;
        pcs[2] = 32'h8000_0000; pcs[3] = 32'h0000_00FC;
        for (int i = 0; i < 4; i++) begin
            issue0(pcs[i], ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL fault_accept: pc=%h not accepted, want accepted", pcs[i]);
            end
        end
        drain0(ok);
        tick();
        n_tests++;
        if (!ok || f0.inst !== 32'hDEAD_BEEF || f0.inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_hold: got inst=%h valid=%b, want inst=deadbeef valid=0", f0.inst, f0.inst_valid);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int base;
        base = pulses0;
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (f0.ready !== ((k % (LAT0 + 1)) == 0)) begin
                n_fail++;
                $display("FAIL hold_ready k=%0d: got %b, want %b", k, f0.ready, (k % (LAT0 + 1)) == 0);
            end
            drive0(1'b1, 32'd0);
        end
        n_tests++;
        if (pulses0 - base != 3) begin
            n_fail++;
            $display("FAIL hold_pulses: got %0d, want 3", pulses0 - base);
        end
        f0.fetch_req = 1'b0;
        drain0(ok);
        n_tests++;
        if (!ok || pulses0 - base != 4) begin
            n_fail++;
            $display("FAIL hold_drain: got %0d pulses %0d pending, want 4 pulses 0 pending", pulses0 - base, sb0.size());
        end
    endtask

    // Write on capture edge (bypass), one edge after capture (stale), and mid-WAIT (visible).
    task automatic test_load_bypass();
        bit ok;
        exp_t e;
        logic [31:0] want [3];
        int delay [3];
        logic [31:0] wdata [3];
        want[0] = 32'h5555_5555; delay[0] = LAT0 - 1; wdata[0] = 32'h5555_5555;
        want[1] = 32'hAAAA_AAAA; delay[1] = LAT0;     wdata[1] = 32'h5555_5555;
        want[2] = 32'h1234_5678; delay[2] = LAT0 - 2; wdata[2] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            do_load(6'd2, 32'hAAAA_AAAA);
            n_tests++;
            if (f0.ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass_ready case %0d: got %b, want 1", i, f0.ready);
            end
            e.inst = want[i]; e.fault = 1'b0; e.acc = cyc + 1;
            sb0.push_back(e);
            f0.fetch_req = 1'b1; f0.pc = 32'd8;
            tick();
            f0.fetch_req = 1'b0;
            repeat (delay[i]) tick();
            do_load(6'd2, wdata[i]);
            drain0(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL bypass_drain case %0d: got %0d pending, want 0", i, sb0.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        issue0(32'd4, ok);
        reset = 1'b1;
        #1;
        n_tests++;
        if (f0.inst !== 32'd0 || f0.fault !== 1'b0 || f0.inst_valid !== 1'b0 || f0.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: got inst=%h fault=%b valid=%b ready=%b, want 0/0/0/1",
                     f0.inst, f0.fault, f0.inst_valid, f0.ready);
        end
        sb0.delete();
        sb1.delete();
        f0.ld_en = 1'b1; f0.ld_addr = 6'd1; f0.ld_data = 32'hFFFF_FFFF;
        f1.ld_en = 1'b1; f1.ld_addr = 6'd1; f1.ld_data = 32'hFFFF_FFFF;
        tick();
        tick();
        f0.ld_en = 1'b0;
        f1.ld_en = 1'b0;
        reset = 1'b0;
        n_tests++;
        if (f0.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b, want 1", f0.ready);
        end
        base = pulses0;
        repeat (5) drive0(1'b0, 32'd0);
        n_tests++;
        if (pulses0 != base) begin
            n_fail++;
            $display("FAIL midreset_ghost: got %0d pulses after release, want 0", pulses0 - base);
        end
        issue0(32'd4, ok);
        drain0(ok);
        n_tests++;
        if (!ok || f0.inst !== 32'h2042_000A) begin
            n_fail++;
            $display("FAIL midreset_mem: got inst=%h, want 2042000a", f0.inst);
        end
    endtask

    task automatic test_latency1();
        bit ok;
        int base;
        base = pulses1;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (f1.ready !== ((k % (LAT1 + 1)) == 0)) begin
                n_fail++;
                $display("FAIL lat1_ready k=%0d: got %b, want %b", k, f1.ready, (k % (LAT1 + 1)) == 0);
            end
            drive1(1'b1, 32'(((k / 2) % 2) * 4));
        end
        n_tests++;
        if (pulses1 - base != 3) begin
            n_fail++;
            $display("FAIL lat1_pulses: got %0d, want 3", pulses1 - base);
        end
        f1.fetch_req = 1'b0;
        drain1(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lat1_drain: got %0d pending, want 0", sb1.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fault();
        test_hold();
        test_load_bypass();
        test_reset_mid();
        test_latency1();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
